// File: rtl/trp_buf_pkg.sv
// Shared types for the transpose buffer responder.
// Holds the FSM state type. The states are one-hot encoded to match the
// other transpose blocks.
package trp_buf_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b01,  // zeroing sweep in progress, array not serviceable
        ST_READY = 2'b10   // normal read/write service
    } trp_buf_state_t;

endpackage

// File: rtl/trp_rd_pipe.sv
// Fixed-latency read return pipe for trp_buf_resp.
// RLAT-deep shift pipe of {valid, data}. Stage 0 takes the selected read
// data. The last stage drives the response. A data stage only loads when a
// valid entry moves into it, so the output data holds between responses.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_vld       request accepted this cycle
//   in_data      data sampled for that request
//   out_vld      response valid (one per accepted request, in order)
//   out_data     response data, held while out_vld is low
//   inflight     requests accepted but not yet returned
module trp_rd_pipe #(
    parameter int DW   = 512,
    parameter int RLAT = 2,
    parameter int IFW  = $clog2(RLAT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data,
    output logic [IFW-1:0] inflight
);

    logic [RLAT-1:0] vld;
    logic [DW-1:0]   dat [RLAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < RLAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_vld;
            if (in_vld) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < RLAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    // The count covers requests accepted but not yet consumed. A response
    // leaves the count on the edge after it has been presented on out_vld.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({in_vld, out_vld})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign out_vld  = vld[RLAT-1];
    assign out_data = dat[RLAT-1];

endmodule

// File: rtl/trp_buf_resp.sv
// Line-addressed buffer responder: the memory side of the transpose engine's
// read/write port. After reset or clr_pulse it sweeps zeros through every
// line. It then serves reads with a fixed latency RLAT and absorbs writes.
// Protocol misuse latches sticky error flags.
//
// Handshake: there is no backpressure. Each cycle with raddr_vld=1 is one
// accepted read. Exactly RLAT cycles later it yields one rdata_vld=1 cycle,
// and responses come back in request order. Each cycle with wdata_vld=1 is
// one write attempt. rdata holds its value while rdata_vld=0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   clr_pulse           restart the zeroing sweep and clear sticky errors
//   raddr, raddr_vld    read request
//   rdata, rdata_vld    read response
//   waddr, wdata,
//   wdata_vld           line write
//   busy                high while the zeroing sweep runs
//   inflight            reads issued but not yet returned
//   err_oor, err_busy   sticky: out-of-range access / access while busy
//   state_dbg           current FSM state
module trp_buf_resp
    import trp_buf_pkg::*;
#(
    parameter int AW    = 16,
    parameter int BUFFD = 64,
    parameter int LINES = 1024,
    parameter int RLAT  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr_pulse,
    input  logic [AW-1:0]               raddr,
    input  logic                        raddr_vld,
    output logic [BUFFD*8-1:0]          rdata,
    output logic                        rdata_vld,
    input  logic [AW-1:0]               waddr,
    input  logic [BUFFD*8-1:0]          wdata,
    input  logic                        wdata_vld,
    output logic                        busy,
    output logic [$clog2(RLAT+1)-1:0]   inflight,
    output logic                        err_oor,
    output logic                        err_busy,
    output trp_buf_state_t              state_dbg
);

    localparam int DW = BUFFD * 8;
    localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;

    reg [DW-1:0] mem [LINES];

    trp_buf_state_t state, state_d;
    logic [IW-1:0]  clr_idx, clr_idx_d;

    logic          rd_oor, wr_oor, wr_en;
    logic [DW-1:0] rd_sel;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_d;
            clr_idx <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        clr_idx_d = clr_idx;
        case (state)
            ST_CLEAR: begin
                if (clr_idx == IW'(LINES - 1)) begin
                    state_d = ST_READY;
                end else begin
                    clr_idx_d = clr_idx + IW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
        // A clear command wins in every state, including a restart mid-sweep.
        if (clr_pulse) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end
    end

    assign busy      = (state == ST_CLEAR);
    assign state_dbg = state;

    // ---------------- array ----------------
    assign rd_oor = (32'(raddr) >= 32'(LINES));
    assign wr_oor = (32'(waddr) >= 32'(LINES));
    assign wr_en  = wdata_vld && !busy && !wr_oor;

    // The sweep owns the write port while busy. User writes are dropped then.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Read data captured on the request edge. A same-cycle write to the same
    // line is forwarded. Busy or out-of-range reads return zero.
    always_comb begin
        rd_sel = '0;
        if (!busy && !rd_oor) begin
            if (wr_en && (waddr == raddr)) begin
                rd_sel = wdata;
            end else begin
                rd_sel = mem[raddr[IW-1:0]];
            end
        end
    end

    trp_rd_pipe #(
        .DW   (DW),
        .RLAT (RLAT)
    ) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (raddr_vld),
        .in_data  (rd_sel),
        .out_vld  (rdata_vld),
        .out_data (rdata),
        .inflight (inflight)
    );

    // ---------------- sticky errors ----------------
    // A request coinciding with clr_pulse is not flagged.
    always_ff @(posedge clk) begin
        if (reset || clr_pulse) begin
            err_oor  <= 1'b0;
            err_busy <= 1'b0;
        end else begin
            if ((raddr_vld && rd_oor) || (wdata_vld && wr_oor)) begin
                err_oor <= 1'b1;
            end
            if (busy && (raddr_vld || wdata_vld)) begin
                err_busy <= 1'b1;
            end
        end
    end

endmodule
